// File: rtl/debounce_bank.sv
// Multi-channel push-button/switch debouncer: 2-FF synchroniser, shared sample-tick
// prescaler, per-channel stability counter and registered rise/fall pulses.
module debounce_bank #(
  parameter int CHANNELS     = 4,
  parameter int TICK_DIV     = 4,
  parameter int STABLE_COUNT = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] button_in,
  output logic [CHANNELS-1:0] button_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic                changed
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_COUNT > 1) ? $clog2(STABLE_COUNT) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(STABLE_COUNT - 1);

  logic [CHANNELS-1:0] sync1_reg;
  logic [CHANNELS-1:0] sync2_reg;
  logic [PW-1:0]       presc_reg;
  logic [PW-1:0]       presc_next;
  logic                tick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= button_in;
      sync2_reg <= sync1_reg;
    end
  end

  // With TICK_DIV=1 the prescaler sits at 0, which is also its last value, so tick stays high.
  assign tick = (presc_reg == PRESC_LAST);

  always_comb begin
    presc_next = presc_reg + PW'(1);
    if (tick) begin
      presc_next = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_next;
    end
  end

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
      logic [CW-1:0] cnt_reg;
      logic [CW-1:0] cnt_next;
      logic          out_reg;
      logic          out_next;
      logic          rise_reg;
      logic          rise_next;
      logic          fall_reg;
      logic          fall_next;

      always_comb begin
        cnt_next  = cnt_reg;
        out_next  = out_reg;
        rise_next = 1'b0;
        fall_next = 1'b0;
        if (tick) begin
          // Agreement with the current level (including a bounce back) restarts the count.
          if (sync2_reg[gi] == out_reg) begin
            cnt_next = '0;
          end else if (cnt_reg == CNT_LAST) begin
            cnt_next  = '0;
            out_next  = sync2_reg[gi];
            rise_next = sync2_reg[gi];
            fall_next = ~sync2_reg[gi];
          end else begin
            cnt_next = cnt_reg + CW'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          cnt_reg  <= '0;
          out_reg  <= 1'b0;
          rise_reg <= 1'b0;
          fall_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          out_reg  <= out_next;
          rise_reg <= rise_next;
          fall_reg <= fall_next;
        end
      end

      assign button_out[gi] = out_reg;
      assign rise_pulse[gi] = rise_reg;
      assign fall_pulse[gi] = fall_reg;
    end
  endgenerate

  assign changed = |(rise_pulse | fall_pulse);

endmodule

// File: tb/tb_debounce_bank.sv
// Scoreboard bench for debounce_bank: one instance at TICK_DIV=1/STABLE_COUNT=3 and one
// at TICK_DIV=4/STABLE_COUNT=2; each output pulse is matched against a queued expectation.
module tb_debounce_bank;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Number of rising edges so far; stable whenever sampled on the falling edge.
  int cyc = 0;
  always @(posedge clk) cyc++;

  logic       rst_a = 1'b1;
  logic       rst_b = 1'b1;
  logic [3:0] bin_a = 4'b0000;
  logic [3:0] bin_b = 4'b0000;
  logic [3:0] out_a, rise_a, fall_a;
  logic [3:0] out_b, rise_b, fall_b;
  logic       chg_a, chg_b;

  debounce_bank #(.CHANNELS(4), .TICK_DIV(1), .STABLE_COUNT(3)) u_dut_a (
    .clk        (clk),
    .reset      (rst_a),
    .button_in  (bin_a),
    .button_out (out_a),
    .rise_pulse (rise_a),
    .fall_pulse (fall_a),
    .changed    (chg_a)
  );

  debounce_bank #(.CHANNELS(4), .TICK_DIV(4), .STABLE_COUNT(2)) u_dut_b (
    .clk        (clk),
    .reset      (rst_b),
    .button_in  (bin_b),
    .button_out (out_b),
    .rise_pulse (rise_b),
    .fall_pulse (fall_b),
    .changed    (chg_b)
  );

  typedef struct {
    int         at;
    logic [3:0] out;
    logic [3:0] rise;
    logic [3:0] fall;
  } exp_t;

  exp_t exp_a[$];
  exp_t exp_b[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic exp_t mk(input int at, input logic [3:0] o, input logic [3:0] r,
                              input logic [3:0] f);
    exp_t e;
    e.at   = at;
    e.out  = o;
    e.rise = r;
    e.fall = f;
    return e;
  endfunction

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b (cyc %0d)", name, act, req, cyc);
    end else begin
      $display("%s cyc=%0d value=%b ok", name, cyc, act);
    end
  endtask

  task automatic judge(input string tag, input int have, input exp_t e,
                       input logic [3:0] o, input logic [3:0] r, input logic [3:0] f);
    n_cmp++;
    if (have == 0) begin
      n_fail++;
      $display("FAIL %s_unexpected_event: got cyc=%0d out=%b rise=%b fall=%b, required no event",
               tag, cyc, o, r, f);
    end else if (cyc != e.at || o !== e.out || r !== e.rise || f !== e.fall) begin
      n_fail++;
      $display("FAIL %s_event: got cyc=%0d out=%b rise=%b fall=%b, required cyc=%0d out=%b rise=%b fall=%b",
               tag, cyc, o, r, f, e.at, e.out, e.rise, e.fall);
    end else begin
      $display("%s event cyc=%0d out=%b rise=%b fall=%b ok", tag, cyc, o, r, f);
    end
  endtask

  // Monitors: every cycle with changed=1 is one transaction.
  exp_t e_a, e_b;
  int   have_a, have_b;
  always @(negedge clk) begin
    if (chg_a === 1'b1) begin
      have_a = exp_a.size();
      if (have_a != 0) e_a = exp_a.pop_front();
      judge("a", have_a, e_a, out_a, rise_a, fall_a);
    end
    if (chg_b === 1'b1) begin
      have_b = exp_b.size();
      if (have_b != 0) e_b = exp_b.pop_front();
      judge("b", have_b, e_b, out_b, rise_b, fall_b);
    end
  end

  // TICK_DIV=1, STABLE_COUNT=3: a change driven at cyc c shows at cyc c+5.
  task automatic run_a();
    wait_cyc(4);  bin_a[0] = 1'b1; exp_a.push_back(mk(9, 4'b0001, 4'b0001, 4'b0000));
    // Bounce on channel 1: 2 high, 1 low, 1 high, then low.
    wait_cyc(12); bin_a[1] = 1'b1;
    wait_cyc(14); bin_a[1] = 1'b0;
    wait_cyc(15); bin_a[1] = 1'b1;
    wait_cyc(16); bin_a[1] = 1'b0;
    wait_cyc(20); bin_a[1] = 1'b1; exp_a.push_back(mk(25, 4'b0011, 4'b0010, 4'b0000));
    wait_cyc(28); bin_a[3] = 1'b1; exp_a.push_back(mk(33, 4'b1011, 4'b1000, 4'b0000));
    wait_cyc(36); bin_a[1] = 1'b0; exp_a.push_back(mk(41, 4'b1001, 4'b0000, 4'b0010));
    wait_cyc(44); bin_a = 4'b0000; exp_a.push_back(mk(49, 4'b0000, 4'b0000, 4'b1001));
    wait_cyc(52); chk("a_level_after_release", out_a, 4'b0000);
    // Reset pulse after three edges of a pending rise.
    wait_cyc(56); bin_a[2] = 1'b1;
    wait_cyc(59); #2 rst_a = 1'b1;
    #1 chk("a_rst_midcount_out", out_a, 4'b0000);
    wait_cyc(60); rst_a = 1'b0; exp_a.push_back(mk(65, 4'b0100, 4'b0100, 4'b0000));
    wait_cyc(66); chk("a_level_after_midcount", out_a, 4'b0100);
    // All high, then asynchronous reset while the rise pulse is showing.
    wait_cyc(68); bin_a = 4'hF; exp_a.push_back(mk(73, 4'b1111, 4'b1011, 4'b0000));
    wait_cyc(73); #2 rst_a = 1'b1;
    #1;
    chk("a_rst_async_out", out_a, 4'b0000);
    chk("a_rst_async_rise", rise_a, 4'b0000);
    chk("a_rst_async_fall", fall_a, 4'b0000);
    chk("a_rst_async_changed", {3'b000, chg_a}, 4'b0000);
    for (int k = 74; k <= 77; k++) begin
      wait_cyc(k);
      chk("a_rst_held_out", out_a, 4'b0000);
      chk("a_rst_held_changed", {3'b000, chg_a}, 4'b0000);
    end
    wait_cyc(78); rst_a = 1'b0; exp_a.push_back(mk(83, 4'b1111, 4'b1111, 4'b0000));
    wait_cyc(84); chk("a_level_after_reset", out_a, 4'b1111);
  endtask

  // TICK_DIV=4, STABLE_COUNT=2, released at cyc 2: ticks on edges 6, 10, 14, ...
  task automatic run_b();
    wait_cyc(4);  bin_b[0] = 1'b1; exp_b.push_back(mk(14, 4'b0001, 4'b0001, 4'b0000));
    // Three-cycle glitch whose synchronised copy straddles only the tick at edge 18.
    wait_cyc(14); bin_b[1] = 1'b1;
    wait_cyc(17); bin_b[1] = 1'b0;
    wait_cyc(24); bin_b[0] = 1'b0; exp_b.push_back(mk(34, 4'b0000, 4'b0000, 4'b0001));
    wait_cyc(35); bin_b[2] = 1'b1; exp_b.push_back(mk(42, 4'b0100, 4'b0100, 4'b0000));
    wait_cyc(44); chk("b_level_final", out_b, 4'b0100);
  endtask

  initial begin
    wait_cyc(2);
    chk("a_reset_out", out_a, 4'b0000);
    chk("a_reset_rise", rise_a, 4'b0000);
    chk("a_reset_fall", fall_a, 4'b0000);
    chk("a_reset_changed", {3'b000, chg_a}, 4'b0000);
    chk("b_reset_out", out_b, 4'b0000);
    chk("b_reset_changed", {3'b000, chg_b}, 4'b0000);
    rst_a = 1'b0;
    rst_b = 1'b0;
    fork
      run_a();
      run_b();
    join
    wait_cyc(100);
    n_cmp++;
    if (exp_a.size() != 0) begin
      n_fail++;
      $display("FAIL a_missing_events: %0d outstanding, required 0", exp_a.size());
    end
    n_cmp++;
    if (exp_b.size() != 0) begin
      n_fail++;
      $display("FAIL b_missing_events: %0d outstanding, required 0", exp_b.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/debounce_bank.md
# debounce_bank

Parametrised multi-channel debouncer for raw push-button and switch inputs. Each channel is synchronised into the `clk` domain. Each channel's debounced level updates only after the synchronised input has differed from it for `STABLE_COUNT` consecutive sample ticks. A shared prescaler sets the tick rate. The block also gives one-cycle rise/fall pulses per channel, so downstream control logic needs no separate edge detectors.

## Interface
- `CHANNELS`, 4: number of independent input channels (≥1).
- `TICK_DIV`, 4: clock cycles per sample tick (≥1; 1 = sample every cycle).
- `STABLE_COUNT`, 3: consecutive differing ticks required to change the output (≥1).
- `clk`  in  1  system clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `button_in`  in  CHANNELS  raw asynchronous inputs.
- `button_out`  out  CHANNELS  debounced levels, registered.
- `rise_pulse`  out  CHANNELS  one-clk pulse when `button_out[i]` goes 0→1, registered.
- `fall_pulse`  out  CHANNELS  one-clk pulse when `button_out[i]` goes 1→0, registered.
- `changed`  out  1  OR-reduction of `rise_pulse | fall_pulse`, combinational from the registers.

## Operation
- Reset values: `button_out`=0, `rise_pulse`=0, `fall_pulse`=0, `changed`=0. Both synchroniser stages, all channel counters and the prescaler are also 0.
- Synchroniser: 2-FF per channel (`s1 <= button_in`, `s2 <= s1`). Only `s2` feeds the debounce logic.
- Prescaler:
  - Counts 0..TICK_DIV-1 and wraps to 0.
  - `tick` = (prescaler == TICK_DIV-1).
  - With TICK_DIV=1, `tick` is constantly 1.
- Per-channel counter:
  - Width is ceil(log2(STABLE_COUNT)), minimum 1 bit.
  - Range 0..STABLE_COUNT-1; it never wraps.
- Per channel i, on a clock edge with `tick`=1:
  - `s2[i] == button_out[i]`: counter ← 0. This covers a bounce back to the current level.
  - Otherwise, counter == STABLE_COUNT-1: `button_out[i]` ← `s2[i]`, counter ← 0, and the matching pulse bit ← 1.
  - Otherwise: counter ← counter+1.
- Edge with `tick`=0: counters and `button_out` hold.
- `rise_pulse` and `fall_pulse` are cleared on every edge on which they are not set. Each pulse is therefore high for exactly one clk, in the same cycle that `button_out[i]` first shows its new value.
- Channels are fully independent. Simultaneous transitions on any subset of channels produce pulses on all of those channels in the same cycle.
- `rise_pulse[i]` and `fall_pulse[i]` are never high together.

## Timing
- TICK_DIV=1: after `button_in[i]` settles before edge 0, `button_out[i]` and its pulse update on edge 2+STABLE_COUNT-1. This is the (2+STABLE_COUNT)th edge: 2 synchroniser edges plus STABLE_COUNT tick edges.
- TICK_DIV>1: latency is 2 + (STABLE_COUNT-1)·TICK_DIV + 1 to 2 + STABLE_COUNT·TICK_DIV edges, depending on prescaler phase.
- A synchronised glitch shorter than STABLE_COUNT ticks never changes `button_out` and never pulses.
- Input that reverts after a partial count: the count restarts from 0 on the next differing tick.
- Reset assertion:
  - Takes effect asynchronously, mid-cycle included.
  - Discards any partial count.
  - Pulses in flight are cleared, not delivered.
- After reset deasserts with `button_in[i]`=1: `rise_pulse[i]` fires after the full latency above. Prescaler phase restarts at 0.
- Throughput: one accepted transition per channel per STABLE_COUNT ticks at most.

## Test plan
- Reset: CHANNELS=4, `button_in`=4'hF, toggle `reset` high mid-cycle. All outputs go to 0 before the next edge and stay 0 while reset is held.
- Clean press: TICK_DIV=1, STABLE_COUNT=3, `button_in[0]` 0→1 held before edge 0.
  - `button_out[0]`=1 and `rise_pulse`=4'b0001 after edge 4 (5th edge).
  - `changed`=1 for exactly that one cycle.
- Bounce rejection: `button_in[1]` high for 2 cycles, low for 1, high for 1, low.
  - No change on `button_out` and no pulses.
  - Then held high: rise occurs on the 5th edge after the last transition.
- Simultaneous release: channels 0 and 3 high, both fall in the same cycle. `fall_pulse`=4'b1001 in a single cycle and `button_out`=4'b0000 from that cycle onward.
- Prescaler: TICK_DIV=4, STABLE_COUNT=2.
  - A held change updates within 7..10 edges.
  - A 3-cycle glitch aligned to straddle one tick is ignored.
- Reset mid-count: TICK_DIV=1, STABLE_COUNT=3, input rises and `reset` pulses after 3 edges. `button_out` stays 0 with no pulse, and a full 5-edge latency follows reset release.
